audio_cfg_master: RTL and testbench
===================================

AUDIO_CFG_MASTER -- requirements
Module: audio_cfg_master

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 4, meaning the number of table entries written per sequence (range 1..16).
REQ-002 The block SHALL have parameter ADDR_W, default 2, meaning the Avalon-MM address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock.
REQ-004 The block SHALL have port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, meaning the request to run the configuration sequence.
REQ-006 The block SHALL have port busy, output, 1, meaning a sequence is in progress.
REQ-007 The block SHALL have port done, output, 1, meaning a one-cycle pulse at sequence end.
REQ-008 The block SHALL have port error, output, 1, meaning a sticky readback mismatch flag.
REQ-009 The block SHALL have port address, output, ADDR_W, meaning the Avalon-MM address.
REQ-010 The block SHALL have port chipselect, output, 1, meaning the Avalon-MM transfer valid.
REQ-011 The block SHALL have port write_n, output, 1, meaning active-low write; chipselect=1 with write_n=1 is a read.
REQ-012 The block SHALL have port writedata, output, 32, meaning the Avalon-MM write data.
REQ-013 The block SHALL have port readdata, input, 32, meaning the Avalon-MM read data, valid in the accept cycle (zero read latency).
REQ-014 The block SHALL have port waitrequest, input, 1, meaning the slave stall; a transfer is accepted in a cycle with chipselect=1 and waitrequest=0.

Function
REQ-015 The FSM SHALL have the states IDLE, WRITE, READ and DONE.
REQ-016 In IDLE, start=1 SHALL clear the index to 0, set busy, and enter WRITE on the next cycle; an IDLE→WRITE transition does not clear error.
REQ-017 In WRITE, the block SHALL drive chipselect=1, write_n=0, address=tbl_addr[idx] and writedata=tbl_data[idx], holding all four stable while waitrequest=1.
REQ-018 On WRITE accept, the block SHALL go to READ when verify is compiled in; otherwise it SHALL increment idx and stay in WRITE, or enter DONE when idx=NUM_WORDS-1.
REQ-019 In READ, the block SHALL drive chipselect=1, write_n=1 and the same address, and hold them while waitrequest=1.
REQ-020 On READ accept, the block SHALL compare (readdata & tbl_mask[idx]) with (tbl_data[idx] & tbl_mask[idx]), set error on mismatch, then advance idx or enter DONE as in REQ-018.
REQ-021 A mismatch SHALL NOT abort the sequence; all NUM_WORDS entries are always written.
REQ-022 In DONE, the block SHALL assert done for exactly 1 cycle, deassert busy in that same cycle, and return to IDLE.
REQ-023 Outside WRITE and READ, the block SHALL drive chipselect=0, write_n=1, address=0 and writedata=0.
REQ-024 The block SHALL ignore start while busy=1 or in DONE; start is level-sampled in IDLE only.
REQ-025 A start received in IDLE SHALL clear error on the cycle of entry to WRITE, which overrides REQ-016; error therefore reflects the most recent sequence only.
REQ-026 Back-to-back transfers SHALL be allowed: the next entry's WRITE is driven in the cycle after accept, with no idle bubble.
REQ-027 The minimum sequence length with waitrequest=0 SHALL be 1 + NUM_WORDS×(1 or 2) + 1 cycles from start to done.

Reset
REQ-028 Asserting reset_n=0 SHALL, asynchronously, force the state to IDLE, idx=0, busy=0, done=0, error=0, chipselect=0, write_n=1, address=0 and writedata=0, including mid-transfer.
REQ-029 After reset release, the block SHALL take no action until start is asserted.

Configuration
REQ-030 The macro AUDIO_CFG_READBACK_VERIFY_EN SHALL control readback: when defined, the READ state and the compare logic are built.
REQ-031 When AUDIO_CFG_READBACK_VERIFY_EN is undefined, READ SHALL be absent, error SHALL be tied to 0, and readdata SHALL be unused.

Structure
REQ-032 The shared package audio_cfg_pkg SHALL hold the state enum, the default NUM_WORDS, the table entry typedef {addr, data, mask} and the default table constants.
REQ-033 The default table SHALL be: entry0 addr 0, data 0x0000_0155, mask 0x3FF; entries 1..3 addr 0, data 0x2AA, 0x3FF and 0x000, mask 0x3FF.
REQ-034 The sub-module audio_cfg_rom SHALL provide the table as a combinational lookup on idx.

Verification
REQ-035 Reset mid-WRITE with waitrequest=1 → the next cycle shows chipselect=0, busy=0 and state IDLE; a later start runs the full sequence from idx=0.
REQ-036 Start with waitrequest=0 and a slave echoing writes → 4 writes of 0x155, 0x2AA, 0x3FF and 0x000; done pulses at cycle 10 (verify on) or cycle 6 (verify off); error=0.
REQ-037 waitrequest held at 1 for 3 cycles on entry1 → address and writedata stay 0x2AA-stable for 4 cycles, with no duplicate accept.
REQ-038 Slave returns 0x000 on entry2 readback → error=1 at that accept, the sequence still completes, and done pulses once.
REQ-039 Start pulsed again while busy, then again after done → the first is ignored, the second clears error and reruns the sequence.
REQ-040 Build without AUDIO_CFG_READBACK_VERIFY_EN → no read transfers (write_n=0 on every chipselect), and error stays 0.

Source files
------------

// File: rtl/audio_cfg_pkg.sv
// Shared types and default register table for the audio codec configuration master.
// The readback feature is selected by the AUDIO_CFG_READBACK_VERIFY_EN macro in the top.
package audio_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } cfg_state_e;

   localparam int DEF_NUM_WORDS = 4;
   localparam int IDX_W         = 4;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
   } cfg_entry_t;

   localparam cfg_entry_t DEF_ENTRY0 = '{addr: 16'h0000, data: 32'h0000_0155, mask: 32'h0000_03FF};
   localparam cfg_entry_t DEF_ENTRY1 = '{addr: 16'h0000, data: 32'h0000_02AA, mask: 32'h0000_03FF};
   localparam cfg_entry_t DEF_ENTRY2 = '{addr: 16'h0000, data: 32'h0000_03FF, mask: 32'h0000_03FF};
   localparam cfg_entry_t DEF_ENTRY3 = '{addr: 16'h0000, data: 32'h0000_0000, mask: 32'h0000_03FF};

   // Indices past the populated table read as an all-zero entry (mask 0 never mismatches).
   function automatic cfg_entry_t default_entry(input logic [IDX_W-1:0] idx);
      cfg_entry_t e;
      case (idx)
         4'd0:    e = DEF_ENTRY0;
         4'd1:    e = DEF_ENTRY1;
         4'd2:    e = DEF_ENTRY2;
         4'd3:    e = DEF_ENTRY3;
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/audio_cfg_rom.sv
// Combinational lookup of the configuration table entry selected by idx.
module audio_cfg_rom
   import audio_cfg_pkg::*;
(
   input  logic [3:0]  idx,
   output logic [15:0] addr,
   output logic [31:0] data,
   output logic [31:0] mask
);

   cfg_entry_t entry_s;

   // Table decode for the requested index.
   always_comb begin
      entry_s = default_entry(idx);
      addr    = entry_s.addr;
      data    = entry_s.data;
      mask    = entry_s.mask;
   end

endmodule

// File: rtl/audio_cfg_master.sv
// Avalon-MM master that writes a fixed register table into an audio codec on start.
// Define AUDIO_CFG_READBACK_VERIFY_EN to read back and mask-compare each entry after writing.
module audio_cfg_master
   import audio_cfg_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int ADDR_W    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] address,
   output logic              chipselect,
   output logic              write_n,
   output logic [31:0]       writedata,
   input  logic [31:0]       readdata,
   input  logic              waitrequest
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   cfg_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              cs_q, cs_d;
   logic              wr_n_q, wr_n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              accept_s;
   logic [15:0]       nxt_addr_s;
   logic [31:0]       nxt_data_s;
   logic [31:0]       nxt_mask_s;
   logic              unused_s;

   assign accept_s = cs_q & ~waitrequest;

   // Outputs are registered, so the bus fields come from the entry the FSM is about to present.
   audio_cfg_rom u_rom_nxt (
      .idx  (idx_d),
      .addr (nxt_addr_s),
      .data (nxt_data_s),
      .mask (nxt_mask_s)
   );

`ifdef AUDIO_CFG_READBACK_VERIFY_EN
   logic [15:0] cur_addr_s;
   logic [31:0] cur_data_s;
   logic [31:0] cur_mask_s;
   logic        match_s;

   audio_cfg_rom u_rom_cur (
      .idx  (idx_q),
      .addr (cur_addr_s),
      .data (cur_data_s),
      .mask (cur_mask_s)
   );

   assign match_s  = ((readdata & cur_mask_s) == (cur_data_s & cur_mask_s));
   assign unused_s = ^{nxt_addr_s[15:ADDR_W], nxt_mask_s, cur_addr_s};
`else
   assign unused_s = ^{nxt_addr_s[15:ADDR_W], nxt_mask_s, readdata};
`endif

   // Next-state, index, status and bus-field computation.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WRITE;
               idx_d   = {IDX_W{1'b0}};
               busy_d  = 1'b1;
               error_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (accept_s) begin
`ifdef AUDIO_CFG_READBACK_VERIFY_EN
               state_d = ST_READ;
`else
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
`endif
            end else begin
               state_d = ST_WRITE;
            end
         end
`ifdef AUDIO_CFG_READBACK_VERIFY_EN
         ST_READ: begin
            if (accept_s) begin
               // Mismatch is recorded but never aborts the remaining writes.
               if (!match_s) begin
                  error_d = 1'b1;
               end else begin
                  error_d = error_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_WRITE;
                  idx_d   = idx_q + 4'd1;
               end
            end else begin
               state_d = ST_READ;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      cs_d    = 1'b0;
      wr_n_d  = 1'b1;
      addr_d  = {ADDR_W{1'b0}};
      wdata_d = 32'h0000_0000;
      if (state_d == ST_WRITE) begin
         cs_d    = 1'b1;
         wr_n_d  = 1'b0;
         addr_d  = nxt_addr_s[ADDR_W-1:0];
         wdata_d = nxt_data_s;
      end else if (state_d == ST_READ) begin
         cs_d   = 1'b1;
         addr_d = nxt_addr_s[ADDR_W-1:0];
      end else begin
         cs_d = 1'b0;
      end
   end

   // Single state/output register bank with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= {IDX_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cs_q    <= 1'b0;
         wr_n_q  <= 1'b1;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         cs_q    <= cs_d;
         wr_n_q  <= wr_n_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign chipselect = cs_q;
   assign write_n    = wr_n_q;
   assign address    = addr_q;
   assign writedata  = wdata_q;

endmodule

// File: tb/tb_audio_cfg_master.sv
// Scoreboard bench for audio_cfg_master: stimulus queues expected bus transfers, a slave/monitor pops them.
module tb_audio_cfg_master;

`ifdef AUDIO_CFG_READBACK_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif
   localparam int XPE  = VER + 1;
   localparam int BADX = (VER == 1) ? 5 : -1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        busy, done, error;
   logic [1:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   audio_cfg_master #(.NUM_WORDS(4), .ADDR_W(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .waitrequest (waitrequest)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] data;
   } xfer_t;

   xfer_t       exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          stall_xfer = -1;
   int          stall_len = 0;
   int          corrupt_xfer = -1;
   int          done_cnt = 0;
   logic [31:0] tbl [4] = '{32'h0000_0155, 32'h0000_02AA, 32'h0000_03FF, 32'h0000_0000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_seq();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{1'b1, 2'd0, tbl[i]});
         if (VER == 1) exp_q.push_back('{1'b0, 2'd0, 32'd0});
      end
   endtask

   // Slave model and monitor: drives waitrequest/readdata and checks every presented transfer.
   initial begin : monitor
      int          xfer_no = 0;
      int          wait_ctr = 0;
      int          pres = 0;
      bit          err_pending = 1'b0;
      logic [31:0] mem [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
      xfer_t       e;
      waitrequest = 1'b0;
      readdata    = 32'd0;
      forever begin
         @(negedge clk);
         if (err_pending) begin
            chk("error_after_bad_read", {31'd0, error}, 32'd1);
            err_pending = 1'b0;
         end
         if (done) begin
            done_cnt++;
            chk("busy_low_with_done", {31'd0, busy}, 32'd0);
         end
         if (!reset_n) begin
            xfer_no = 0; wait_ctr = 0; pres = 0; waitrequest = 1'b0;
         end else if (chipselect) begin
            if (xfer_no == stall_xfer && wait_ctr < stall_len) begin
               waitrequest = 1'b1;
               wait_ctr++;
            end else begin
               waitrequest = 1'b0;
            end
            readdata = (write_n && xfer_no == corrupt_xfer) ? 32'd0 : mem[address];
            pres++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_xfer: got addr 0x%0h write_n %0b, expected no transfer (t=%0t)",
                        address, write_n, $time);
            end else begin
               e = exp_q[0];
               chk("xfer_is_write", {31'd0, !write_n}, {31'd0, e.wr});
               chk("xfer_addr", {30'd0, address}, {30'd0, e.addr});
               if (e.wr) chk("xfer_wdata", writedata, e.data);
               if (!waitrequest) begin
                  void'(exp_q.pop_front());
                  if (e.wr) mem[address] = writedata;
                  if (xfer_no == stall_xfer) chk("stall_cycles_presented", pres, stall_len + 1);
                  if (xfer_no == corrupt_xfer) begin
                     chk("error_before_bad_read", {31'd0, error}, 32'd0);
                     err_pending = 1'b1;
                  end
                  xfer_no++; wait_ctr = 0; pres = 0;
               end
            end
         end else begin
            waitrequest = 1'b0;
            if (!busy) begin
               xfer_no = 0; wait_ctr = 0; pres = 0;
            end
         end
      end
   end

   // One full sequence; start is issued in cycle 1, done is expected in the cycle counted from it.
   task automatic run_seq(input string tag, input int st_x, input int st_n, input int bad_x, input bit poke);
      int cyc;
      int d0;
      int exp_cyc;
      exp_cyc      = ((VER == 1) ? 10 : 6) + ((st_x >= 0) ? st_n : 0);
      stall_xfer   = st_x;
      stall_len    = st_n;
      corrupt_xfer = bad_x;
      push_seq();
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 2;
      chk({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
      chk({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         start = (poke && cyc == 4);
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, cyc, exp_cyc);
      chk({tag, "_error_at_done"}, {31'd0, error}, (VER == 1 && bad_x >= 0) ? 32'd1 : 32'd0);
      if (poke) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
      chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset_n = 1'b0;
      start   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_chipselect", {31'd0, chipselect}, 32'd0);
      chk("rst_write_n", {31'd0, write_n}, 32'd1);
      chk("rst_address", {30'd0, address}, 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_no_action_busy", {31'd0, busy}, 32'd0);
      chk("idle_no_action_cs", {31'd0, chipselect}, 32'd0);

      run_seq("basic", -1, 0, -1, 1'b0);
      run_seq("stall_entry1", XPE, 3, -1, 1'b0);
      run_seq("bad_readback", -1, 0, BADX, 1'b1);
      run_seq("rerun", -1, 0, -1, 1'b0);

      // Reset while entry 1's write is stalled.
      stall_xfer = XPE;
      stall_len  = 1000;
      push_seq();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("stalled_cs", {31'd0, chipselect}, 32'd1);
      chk("stalled_wdata", writedata, 32'h0000_02AA);
      reset_n = 1'b0;
      exp_q.delete();
      stall_xfer = -1;
      #1;
      chk("midrst_cs", {31'd0, chipselect}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_write_n", {31'd0, write_n}, 32'd1);
      chk("midrst_address", {30'd0, address}, 32'd0);
      chk("midrst_writedata", writedata, 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("postrst_idle_cs", {31'd0, chipselect}, 32'd0);
      run_seq("post_reset", -1, 0, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
